data_memory_unit: RTL and testbench

//  Parametrised data memory for the MEM stage. Successor to the fixed 8-bit/256-entry store.

---
 rtl/data_memory_unit.sv | 113 +++++++++++
 tb/tb_data_memory_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - MEM-stage data memory with byte lanes, extension, handshake and clear engine
module data_memory_unit #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              load_signed,
  input  logic [WORD_W-1:0] write_data,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] read_data,
  output logic              err
);

  localparam int BYTES  = WORD_W / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int DEPTH  = (2 ** ADDR_W) / BYTES;
  localparam int IDX_W  = ADDR_W - LANE_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cnt;
  logic [WORD_W-1:0]  mem [DEPTH];

  logic               accept, legal, do_load, do_store, cnt_last;
  logic [IDX_W-1:0]   idx;
  logic [LANE_W-1:0]  lane;
  logic [3:0]         nbytes;
  logic [BYTES-1:0]   be;
  logic [WORD_W-1:0]  wdata_sh, rword, rsh, rext;
  logic               sign;

  assign accept   = req_valid && req_ready;
  assign idx      = addr[ADDR_W-1:LANE_W];
  assign lane     = addr[LANE_W-1:0];
  assign nbytes   = 4'd1 << size;
  assign legal    = (MemRead != MemWrite) && (int'(nbytes) <= BYTES)
                    && ((addr & ADDR_W'(nbytes - 4'd1)) == '0);
  assign do_load  = accept && legal && MemRead;
  assign do_store = accept && legal && MemWrite;
  assign cnt_last = (cnt == IDX_W'(DEPTH - 1));

  // Lane steering: stores shift data up into place, loads shift the word down and extend.
  always_comb begin
    wdata_sh = write_data << {lane, 3'b000};
    rword    = mem[idx];
    rsh      = rword >> {lane, 3'b000};
    sign     = 1'b0;
    be       = '0;
    rext     = '0;
    for (int b = 0; b < BYTES; b++) begin
      be[b] = (b >= int'(lane)) && (b < int'(lane) + int'(nbytes));
      if (b == int'(nbytes) - 1) sign = rsh[8*b+7];
    end
    for (int b = 0; b < BYTES; b++) begin
      rext[8*b +: 8] = (b < int'(nbytes)) ? rsh[8*b +: 8] : {8{sign & load_signed}};
    end
  end

  // Storage has no reset; a reset mid-clear leaves already-zeroed words as they are.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (do_store) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_start) state_nxt = CLEAR;
      CLEAR:   if (cnt_last)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && !clear_start;
    clear_busy = (state == CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      read_data <= '0;
    end else begin
      rsp_valid <= do_load;
      err       <= accept && !legal;
      if (do_load) read_data <= rext;
      if (state == CLEAR) cnt <= cnt_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - self-checking bench for data_memory_unit
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, MemRead, MemWrite;
  logic [7:0]  addr;
  logic [1:0]  size;
  logic        load_signed;
  logic [31:0] write_data;
  logic        clear_start, clear_busy, rsp_valid, err;
  logic [31:0] read_data;

  data_memory_unit #(.WORD_W(32), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .size(size),
    .load_signed(load_signed), .write_data(write_data), .clear_start(clear_start),
    .clear_busy(clear_busy), .rsp_valid(rsp_valid), .read_data(read_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [7:0]  addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wd;
    logic        exp_rsp, exp_err;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        rsp, err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[20];
  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] model_rd = '0;

  function automatic vec_t mk(logic rd, logic wr, logic [7:0] a, logic [1:0] sz, logic sg,
                              logic [31:0] wd, logic er, logic ee, logic [31:0] ed);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.size = sz; v.sgn = sg; v.wd = wd;
    v.exp_rsp = er; v.exp_err = ee; v.exp_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; MemRead = v.rd; MemWrite = v.wr; addr = v.addr;
    size = v.size; load_signed = v.sgn; write_data = v.wd;
    if (v.exp_rsp) model_rd = v.exp_data;
    e.rsp = v.exp_rsp; e.err = v.exp_err; e.data = model_rd;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (rsp_valid !== e.rsp || err !== e.err || read_data !== e.data) begin
      n_fail++;
      $display("FAIL vec addr=%h rd=%b wr=%b size=%0d: got rsp=%b err=%b data=%h exp rsp=%b err=%b data=%h",
               v.addr, v.rd, v.wr, v.size, rsp_valid, err, read_data, e.rsp, e.err, e.data);
    end
  endtask

  task automatic sw(input logic [7:0] a, input logic [31:0] d);
    apply(mk(1'b0, 1'b1, a, 2'd2, 1'b0, d, 1'b0, 1'b0, '0));
  endtask

  task automatic lw(input logic [7:0] a, input logic [31:0] d);
    apply(mk(1'b1, 1'b0, a, 2'd2, 1'b0, '0, 1'b1, 1'b0, d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, busy;
    reset_n = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = '0;
    size = '0; load_signed = 1'b0; write_data = '0; clear_start = 1'b0;

    tbl[0]  = mk(0, 1, 8'h10, 2'd2, 0, 32'h11223344, 0, 0, '0);
    tbl[1]  = mk(0, 1, 8'h11, 2'd0, 0, 32'h000000AA, 0, 0, '0);
    tbl[2]  = mk(1, 0, 8'h10, 2'd2, 0, '0,           1, 0, 32'h1122AA44);
    tbl[3]  = mk(0, 1, 8'h22, 2'd1, 0, 32'h00008001, 0, 0, '0);
    tbl[4]  = mk(1, 0, 8'h22, 2'd1, 1, '0,           1, 0, 32'hFFFF8001);
    tbl[5]  = mk(1, 0, 8'h22, 2'd1, 0, '0,           1, 0, 32'h00008001);
    tbl[6]  = mk(1, 0, 8'h11, 2'd0, 1, '0,           1, 0, 32'hFFFFFFAA);
    tbl[7]  = mk(1, 0, 8'h13, 2'd0, 0, '0,           1, 0, 32'h00000011);
    tbl[8]  = mk(1, 0, 8'h12, 2'd1, 0, '0,           1, 0, 32'h00001122);
    tbl[9]  = mk(0, 1, 8'h00, 2'd2, 0, 32'hCAFEBABE, 0, 0, '0);
    tbl[10] = mk(1, 0, 8'h02, 2'd2, 0, '0,           0, 1, '0);
    tbl[11] = mk(0, 1, 8'h00, 2'd3, 0, 32'hFFFFFFFF, 0, 1, '0);
    tbl[12] = mk(1, 1, 8'h00, 2'd2, 0, 32'h00000000, 0, 1, '0);
    tbl[13] = mk(0, 0, 8'h00, 2'd2, 0, '0,           0, 1, '0);
    tbl[14] = mk(1, 0, 8'h01, 2'd1, 0, '0,           0, 1, '0);
    tbl[15] = mk(1, 0, 8'h00, 2'd2, 0, '0,           1, 0, 32'hCAFEBABE);
    tbl[16] = mk(0, 1, 8'h02, 2'd1, 0, 32'hFFFF7FFF, 0, 0, '0);
    tbl[17] = mk(1, 0, 8'h00, 2'd2, 0, '0,           1, 0, 32'h7FFFBABE);
    tbl[18] = mk(1, 0, 8'h03, 2'd0, 1, '0,           1, 0, 32'h0000007F);
    tbl[19] = mk(1, 0, 8'h02, 2'd0, 1, '0,           1, 0, 32'hFFFFFFFF);

    #3;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_clear_busy", {31'b0, clear_busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    #1 chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 20; i++) apply(tbl[i]);

    // Asynchronous reset in the middle of a cycle while a response is showing
    lw(8'h10, 32'h1122AA44);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("async_rst_read_data", read_data, 32'd0);
    chk("async_rst_err", {31'b0, err}, 32'd0);
    @(negedge clk); reset_n = 1'b1; model_rd = '0;
    #1 chk("async_rst_ready", {31'b0, req_ready}, 32'd1);
    lw(8'h10, 32'h1122AA44);

    // Full clear with a concurrent load that must not be accepted
    for (int i = 0; i < 4; i++) sw(8'(8'h40 + 4*i), 32'hA0B0C0D0 + i);
    sw(8'hFC, 32'h5A5A5A5A);
    @(negedge clk);
    clear_start = 1'b1; req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
    addr = 8'h40; size = 2'd2;
    #1 chk("clear_start_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    clear_start = 1'b0; req_valid = 1'b0;
    chk("clear_req_not_accepted", {30'b0, rsp_valid, err}, 32'd0);
    cyc = 0; busy = 0;
    while (req_ready === 1'b0 && cyc < 200) begin
      if (clear_busy === 1'b1) busy++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("clear_ready_low_cycles", 32'(cyc), 32'd64);
    chk("clear_busy_cycles", 32'(busy), 32'd64);
    chk("clear_busy_done", {31'b0, clear_busy}, 32'd0);
    for (int i = 0; i < 4; i++) lw(8'(8'h40 + 4*i), 32'h0);
    lw(8'hFC, 32'h0);
    lw(8'h10, 32'h0);

    // Reset while the clear counter sits at 10
    for (int i = 0; i < 12; i++) sw(8'(4*i), 32'h100 + i);
    sw(8'hFC, 32'h12345678);
    @(negedge clk); clear_start = 1'b1;
    @(posedge clk); #1; clear_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midclear_rst_busy", {31'b0, clear_busy}, 32'd0);
    chk("midclear_rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk); reset_n = 1'b1; model_rd = '0;
    for (int i = 0; i < 10; i++) lw(8'(4*i), 32'h0);
    lw(8'h28, 32'h10A);
    lw(8'h2C, 32'h10B);
    lw(8'hFC, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
